xgmii_rx_parser: RTL

XGMII_RX_PARSER -- requirements
Module: xgmii_rx_parser

---
 rtl/xgmii_rx_parser.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_rx_parser.sv
`default_nettype none
// ============================================================================
// Module  : xgmii_rx_parser
// Brief   : XGMII RX frame parser - header check, request capture, payload
//           stream. Define RX_MACFILTER_EN to add the destination-MAC filter.
// Rev     : 1.0
// ============================================================================
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hC0DE_1234
`endif

module xgmii_rx_parser (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  input  logic [47:0] if_macaddr,
  output logic [63:0] req_addr,
  output logic [9:0]  req_len,
  output logic        req_bit64,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [7:0]  pkt_count,
  output logic [7:0]  drop_count
);

  localparam logic [2:0]  c_IDLE    = 3'd0;
  localparam logic [2:0]  c_HDR     = 3'd1;
  localparam logic [2:0]  c_ADDR    = 3'd2;
  localparam logic [2:0]  c_PAYLOAD = 3'd3;
  localparam logic [2:0]  c_DROP    = 3'd4;
  localparam logic [15:0] c_ETYPE   = 16'h0800;
  localparam logic [7:0]  c_PROTO   = 8'h11;
  localparam logic [15:0] c_DPORT   = 16'd3422;
  localparam logic [31:0] c_MAGIC   = `MAGIC_CODE;

  logic [2:0]  r_state, w_state_next;
  logic [3:0]  r_idx;
  logic [9:0]  r_remain;
  logic        r_first;
  logic [15:0] r_type, r_dport;
  logic [7:0]  r_proto;
  logic [9:0]  r_len_sh;
  logic        r_bit64_sh;
  logic [7:0]  w_rxc;
  logic [63:0] w_rxd;
  logic        w_sof, w_eof, w_accept, w_fields_ok;
  logic [31:0] w_magic;
  logic [9:0]  w_words;
  logic        w_emit, w_emit_err, w_drop_inc, w_cap_len, w_cap_addr;

  assign w_rxc = dout[71:64];
  assign w_rxd = dout[63:0];
  assign w_sof = (w_rxc == 8'h01) && (w_rxd[7:0] == 8'hFB);
  assign w_eof = (w_rxc != 8'h00) && !w_sof;

  // Lane 2 carries the most significant magic byte.
  assign w_magic     = {w_rxd[23:16], w_rxd[31:24], w_rxd[39:32], w_rxd[47:40]};
  assign w_fields_ok = (r_type == c_ETYPE) && (r_proto == c_PROTO) &&
                       (r_dport == c_DPORT) && (w_magic == c_MAGIC);
  assign w_words     = (r_len_sh == 10'd0) ? 10'd512
                     : ({1'b0, r_len_sh[9:1]} + {9'd0, r_len_sh[0]});

`ifdef RX_MACFILTER_EN
  logic [47:0] r_dst;
  assign w_accept = w_fields_ok &&
                    ((r_dst == if_macaddr) || (r_dst == 48'hFFFF_FFFF_FFFF));
  always_ff @(posedge clk) begin
    if (sys_rst)
      r_dst <= 48'd0;
    else if (rd_en && r_state == c_HDR && r_idx == 4'd1 && !w_sof && !w_eof)
      r_dst <= {w_rxd[7:0], w_rxd[15:8], w_rxd[23:16], w_rxd[31:24], w_rxd[39:32], w_rxd[47:40]};
  end
`else
  logic w_unused_mac;
  assign w_unused_mac = ^if_macaddr;
  assign w_accept     = w_fields_ok;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst)
      r_state <= c_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (rd_en) begin
      case (r_state)
        c_IDLE:    if (w_sof) w_state_next = c_HDR;
        c_HDR: begin
          if (w_sof)                              w_state_next = c_HDR;
          else if (w_eof)                         w_state_next = c_IDLE;
          else if (r_idx == 4'd6 && !w_accept)    w_state_next = c_DROP;
          else if (r_idx == 4'd7)                 w_state_next = c_ADDR;
        end
        c_ADDR: begin
          if (w_sof)      w_state_next = c_HDR;
          else if (w_eof) w_state_next = c_IDLE;
          else            w_state_next = c_PAYLOAD;
        end
        c_PAYLOAD: begin
          if (w_sof)                      w_state_next = c_HDR;
          else if (w_eof)                 w_state_next = c_IDLE;
          else if (r_remain == 10'd1)     w_state_next = c_DROP;
        end
        c_DROP: begin
          if (w_sof)      w_state_next = c_HDR;
          else if (w_eof) w_state_next = c_IDLE;
        end
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  // Payload pops are throttled by the output register; other states always drain.
  always_comb begin
    rd_en      = !sys_rst && !empty && (r_state != c_PAYLOAD || !out_valid || out_ready);
    w_emit     = 1'b0;
    w_emit_err = 1'b0;
    w_drop_inc = 1'b0;
    w_cap_len  = 1'b0;
    w_cap_addr = 1'b0;
    if (rd_en) begin
      case (r_state)
        c_HDR: begin
          if (w_sof || w_eof)                     w_drop_inc = 1'b1;
          else if (r_idx == 4'd6 && !w_accept)    w_drop_inc = 1'b1;
          else if (r_idx == 4'd7)                 w_cap_len  = 1'b1;
        end
        c_ADDR: begin
          if (w_sof || w_eof) w_drop_inc = 1'b1;
          else                w_cap_addr = 1'b1;
        end
        c_PAYLOAD: begin
          w_emit = 1'b1;
          if (w_sof || w_eof) begin
            w_emit_err = 1'b1;
            w_drop_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_idx      <= 4'd0;
      r_remain   <= 10'd0;
      r_first    <= 1'b0;
      r_type     <= 16'd0;
      r_proto    <= 8'd0;
      r_dport    <= 16'd0;
      r_len_sh   <= 10'd0;
      r_bit64_sh <= 1'b0;
      req_addr   <= 64'd0;
      req_len    <= 10'd0;
      req_bit64  <= 1'b0;
      out_data   <= 64'd0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      pkt_count  <= 8'd0;
      drop_count <= 8'd0;
    end else begin
      if (rd_en) begin
        if (w_sof)
          r_idx <= 4'd1;
        else if (r_state == c_HDR || r_state == c_ADDR)
          r_idx <= r_idx + 4'd1;
      end
      if (rd_en && r_state == c_HDR && !w_sof && !w_eof) begin
        case (r_idx)
          4'd2:    r_type  <= {w_rxd[39:32], w_rxd[47:40]};
          4'd3:    r_proto <= w_rxd[63:56];
          4'd5:    r_dport <= {w_rxd[39:32], w_rxd[47:40]};
          default: ;
        endcase
      end
      if (w_cap_len) begin
        r_len_sh   <= w_rxd[9:0];
        r_bit64_sh <= w_rxd[29];
      end
      // Request header is published atomically once the address word lands.
      if (w_cap_addr) begin
        req_addr  <= w_rxd;
        req_len   <= r_len_sh;
        req_bit64 <= r_bit64_sh;
        r_remain  <= w_words;
        r_first   <= 1'b1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        out_err   <= 1'b0;
        if (out_eop && !out_err)
          pkt_count <= pkt_count + 8'd1;
      end
      if (w_emit) begin
        out_valid <= 1'b1;
        if (w_emit_err) begin
          out_data <= 64'd0;
          out_sop  <= 1'b0;
          out_eop  <= 1'b1;
          out_err  <= 1'b1;
        end else begin
          out_data <= w_rxd;
          out_sop  <= r_first;
          out_eop  <= (r_remain == 10'd1);
          out_err  <= 1'b0;
          r_first  <= 1'b0;
          r_remain <= r_remain - 10'd1;
        end
      end
      if (w_drop_inc)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

`default_nettype wire
